// File: rtl/pkt_meta_sched_if.sv
// pkt_meta_sched_if
// Bundles every non-clock signal of the packet/metadata read scheduler.
//   i_pkt_empty / i_pkt_dout / o_pkt_rden    : packet FIFO read side (FWFT, 134b beats)
//   i_meta_empty / i_meta_dout / o_meta_rden : metadata FIFO read side (FWFT)
//   i_out_ready                              : downstream accepts a beat this cycle
//   o_data_valid / o_data                    : registered output beat
//   o_meta_valid / o_meta                    : registered metadata, only with the head beat
//   o_pkt_cnt / o_err_cnt                    : statistics (live only with STAT_CNT_EN)
// Modports: slave = scheduler side, master = FIFO/downstream (environment) side.
interface pkt_meta_sched_if #(
  parameter int META_W = 128,
  parameter int CNT_W  = 32
);
  logic              i_pkt_empty;
  logic [133:0]      i_pkt_dout;
  logic              o_pkt_rden;
  logic              i_meta_empty;
  logic [META_W-1:0] i_meta_dout;
  logic              o_meta_rden;
  logic              i_out_ready;
  logic              o_data_valid;
  logic [133:0]      o_data;
  logic              o_meta_valid;
  logic [META_W-1:0] o_meta;
  logic [CNT_W-1:0]  o_pkt_cnt;
  logic [CNT_W-1:0]  o_err_cnt;

  modport slave (
    input  i_pkt_empty, i_pkt_dout, i_meta_empty, i_meta_dout, i_out_ready,
    output o_pkt_rden, o_meta_rden, o_data_valid, o_data, o_meta_valid, o_meta,
           o_pkt_cnt, o_err_cnt
  );

  modport master (
    output i_pkt_empty, i_pkt_dout, i_meta_empty, i_meta_dout, i_out_ready,
    input  o_pkt_rden, o_meta_rden, o_data_valid, o_data, o_meta_valid, o_meta,
           o_pkt_cnt, o_err_cnt
  );
endinterface

// File: rtl/pkt_meta_sched.sv
// pkt_meta_sched
// Read-side scheduler pairing each buffered packet with its parser metadata word.
// Pops are combinational from state and FIFO heads; output beats are registered,
// so a beat popped in cycle t appears on o_data in cycle t+1.
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   bus     : pkt_meta_sched_if.slave (FIFO read sides, output beat, statistics)
// Build option: define STAT_CNT_EN to implement o_pkt_cnt / o_err_cnt; otherwise
// both are tied to zero and no counter registers exist.
module pkt_meta_sched #(
  parameter int META_W = 128,
  parameter int CNT_W  = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  pkt_meta_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BODY = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam logic [1:0] TAG_BODY   = 2'b00;
  localparam logic [1:0] TAG_HEAD   = 2'b01;
  localparam logic [1:0] TAG_TAIL   = 2'b10;
  localparam logic [1:0] TAG_SINGLE = 2'b11;

  state_e            state_q, state_d;
  logic              gap_q, gap_d;
  logic              data_valid_q, data_valid_d;
  logic [133:0]      data_q, data_d;
  logic              meta_valid_q, meta_valid_d;
  logic [META_W-1:0] meta_q, meta_d;
  logic              pkt_rden_s, meta_rden_s;
  logic              pkt_inc_s, err_inc_s;
  logic [1:0]        tag_s;
  logic              tag_starts_s;

  assign tag_s        = bus.i_pkt_dout[133:132];
  assign tag_starts_s = (tag_s == TAG_HEAD) || (tag_s == TAG_SINGLE);

  // Next-state, pop and output-beat decode.
  always_comb begin
    state_d      = state_q;
    gap_d        = 1'b0;
    pkt_rden_s   = 1'b0;
    meta_rden_s  = 1'b0;
    pkt_inc_s    = 1'b0;
    err_inc_s    = 1'b0;
    data_valid_d = 1'b0;
    data_d       = data_q;
    meta_valid_d = 1'b0;
    meta_d       = meta_q;
    case (state_q)
      IDLE: begin
        // gap_q holds off one cycle after a packet closes so packets never abut.
        if (gap_q || bus.i_pkt_empty) begin
          state_d = IDLE;
        end else if (!tag_starts_s) begin
          pkt_rden_s = 1'b1;
          err_inc_s  = 1'b1;
          state_d    = DROP;
        end else if (!bus.i_meta_empty && bus.i_out_ready) begin
          pkt_rden_s   = 1'b1;
          meta_rden_s  = 1'b1;
          data_valid_d = 1'b1;
          data_d       = bus.i_pkt_dout;
          meta_valid_d = 1'b1;
          meta_d       = bus.i_meta_dout;
          if (tag_s == TAG_SINGLE) begin
            pkt_inc_s = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = BODY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BODY: begin
        if (!bus.i_pkt_empty && bus.i_out_ready) begin
          pkt_rden_s   = 1'b1;
          data_valid_d = 1'b1;
          data_d       = bus.i_pkt_dout;
          if (tag_s == TAG_TAIL) begin
            pkt_inc_s = 1'b1;
            state_d   = IDLE;
          end else if (tag_starts_s) begin
            // Missing tail: close the open packet with this beat retagged as tail.
            data_d[133:132] = TAG_TAIL;
            err_inc_s       = 1'b1;
            state_d         = IDLE;
          end else begin
            state_d = BODY;
          end
        end else begin
          state_d = BODY;
        end
      end
      DROP: begin
        if (!bus.i_pkt_empty) begin
          pkt_rden_s = 1'b1;
          if (tag_s != TAG_BODY) begin
            state_d = IDLE;
          end else begin
            state_d = DROP;
          end
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    gap_d = pkt_rden_s && (state_d == IDLE);
  end

  // State and registered output beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      gap_q        <= 1'b0;
      data_valid_q <= 1'b0;
      data_q       <= 134'd0;
      meta_valid_q <= 1'b0;
      meta_q       <= {META_W{1'b0}};
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      data_valid_q <= data_valid_d;
      data_q       <= data_d;
      meta_valid_q <= meta_valid_d;
      meta_q       <= meta_d;
    end
  end

  // Reset gates the pops directly so an abort mid-packet stops popping at once.
  assign bus.o_pkt_rden   = pkt_rden_s & i_rst_n;
  assign bus.o_meta_rden  = meta_rden_s & i_rst_n;
  assign bus.o_data_valid = data_valid_q;
  assign bus.o_data       = data_q;
  assign bus.o_meta_valid = meta_valid_q;
  assign bus.o_meta       = meta_q;

`ifdef STAT_CNT_EN
  logic [CNT_W-1:0] pkt_cnt_q, err_cnt_q;

  // Statistics counters; wrap naturally at 2^CNT_W.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_cnt_q <= {CNT_W{1'b0}};
      err_cnt_q <= {CNT_W{1'b0}};
    end else begin
      if (pkt_inc_s) begin
        pkt_cnt_q <= pkt_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        pkt_cnt_q <= pkt_cnt_q;
      end
      if (err_inc_s) begin
        err_cnt_q <= err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        err_cnt_q <= err_cnt_q;
      end
    end
  end

  assign bus.o_pkt_cnt = pkt_cnt_q;
  assign bus.o_err_cnt = err_cnt_q;
`else
  logic unused_inc_s;
  assign unused_inc_s  = pkt_inc_s ^ err_inc_s;
  assign bus.o_pkt_cnt = {CNT_W{1'b0}};
  assign bus.o_err_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pkt_meta_sched.sv
// tb_pkt_meta_sched
// Self-checking bench for pkt_meta_sched. FIFOs are modelled as queues; the
// expected output stream is derived from the input beat list by a packet-level
// parser (ref_model), and directed scenarios add cycle-exact timing checks.
module tb_pkt_meta_sched;
  localparam int META_W = 128;
  localparam int CNT_W  = 32;
`ifdef STAT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct {
    logic [133:0]      d;
    logic              mv;
    logic [META_W-1:0] m;
    int                cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pkt_meta_sched_if #(.META_W(META_W), .CNT_W(CNT_W)) bus ();
  pkt_meta_sched #(.META_W(META_W), .CNT_W(CNT_W)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pkt_pops = 0;
  int meta_pops = 0;
  bit ready_now = 1'b0;
  bit pr_last = 1'b0;
  bit ready_last = 1'b0;
  int exp_pkt, exp_err;

  logic [133:0]      pkt_q[$];
  logic [META_W-1:0] meta_q[$];
  logic [133:0]      stream_q[$];
  logic [META_W-1:0] smeta_q[$];
  beat_t             got[$];
  beat_t             exp_q[$];

  function automatic logic [133:0] mk_beat(input logic [1:0] tag);
    logic [131:0] p;
    p = {$urandom, $urandom, $urandom, $urandom, 4'($urandom)};
    return {tag, p};
  endfunction

  function automatic logic [META_W-1:0] rnd_meta();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_fifo();
    bus.i_pkt_empty  = (pkt_q.size() == 0);
    bus.i_pkt_dout   = (pkt_q.size() != 0) ? pkt_q[0] : 134'd0;
    bus.i_meta_empty = (meta_q.size() == 0);
    bus.i_meta_dout  = (meta_q.size() != 0) ? meta_q[0] : {META_W{1'b0}};
    bus.i_out_ready  = ready_now;
  endtask

  // Packet-level reference: walks the beat list by the framing rules.
  task automatic ref_model();
    int i = 0;
    int mi = 0;
    logic [1:0] tag;
    beat_t e;
    bit open;
    exp_q.delete();
    exp_pkt = 0;
    exp_err = 0;
    while (i < stream_q.size()) begin
      tag = stream_q[i][133:132];
      if (tag == 2'b01 || tag == 2'b11) begin
        if (mi >= smeta_q.size()) smeta_q.push_back(rnd_meta());
        e.d = stream_q[i]; e.mv = 1'b1; e.m = smeta_q[mi]; e.cyc = 0;
        mi++; i++;
        exp_q.push_back(e);
        if (tag == 2'b11) begin
          exp_pkt++;
        end else begin
          open = 1'b1;
          while (open && i < stream_q.size()) begin
            tag = stream_q[i][133:132];
            e.d = stream_q[i]; e.mv = 1'b0; e.m = '0;
            if (tag == 2'b10) begin
              exp_pkt++; open = 1'b0;
            end else if (tag != 2'b00) begin
              e.d[133:132] = 2'b10; exp_err++; open = 1'b0;
            end
            exp_q.push_back(e);
            i++;
          end
        end
      end else begin
        exp_err++;
        i++;
        open = 1'b1;
        while (open && i < stream_q.size()) begin
          tag = stream_q[i][133:132];
          i++;
          if (tag != 2'b00) open = 1'b0;
        end
      end
    end
  endtask

  task automatic load();
    foreach (stream_q[i]) pkt_q.push_back(stream_q[i]);
    foreach (smeta_q[i]) meta_q.push_back(smeta_q[i]);
    drive_fifo();
  endtask

  // One clock: sample pops mid-cycle, pop FIFOs and capture outputs after the edge.
  task automatic cycle();
    bit pr, mr;
    @(negedge clk);
    pr = bus.o_pkt_rden;
    mr = bus.o_meta_rden;
    checks++;
    if (pr && bus.i_pkt_empty) begin
      errors++; $display("FAIL pop_empty: pkt_rden=1 while packet FIFO empty (cycle %0d)", cyc);
    end
    checks++;
    if (mr && (bus.i_meta_empty || !pr)) begin
      errors++; $display("FAIL meta_pop: meta_rden=1 pkt_rden=%0b meta_empty=%0b, required pkt pop and meta present", pr, bus.i_meta_empty);
    end
    @(posedge clk);
    #1;
    if (pr) begin void'(pkt_q.pop_front()); pkt_pops++; end
    if (mr) begin void'(meta_q.pop_front()); meta_pops++; end
    cyc++;
    checks++;
    if (bus.o_data_valid && !pr) begin
      errors++; $display("FAIL latency: o_data_valid=1 with no pop in the previous cycle (cycle %0d)", cyc);
    end
    if (bus.o_data_valid) begin
      got.push_back('{d: bus.o_data, mv: bus.o_meta_valid, m: bus.o_meta, cyc: cyc});
    end
    pr_last = pr;
    ready_last = ready_now;
    drive_fifo();
  endtask

  task automatic run_drain(input int budget, output bit timed_out);
    int n = 0;
    while (!(got.size() >= exp_q.size() && pkt_q.size() == 0) && n < budget) begin
      cycle();
      n++;
    end
    timed_out = (n >= budget);
    repeat (3) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ready_now = 1'b0;
    pkt_q.delete(); meta_q.delete(); got.delete();
    stream_q.delete(); smeta_q.delete();
    drive_fifo();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pkt_pops = 0;
    meta_pops = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pkt_q.push_back(mk_beat(2'b01)); pkt_q.push_back(mk_beat(2'b10));
    meta_q.push_back(rnd_meta());
    ready_now = 1'b1;
    drive_fifo();
    #13;
    checks++; if (bus.o_data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %0b expected 0", bus.o_data_valid); end
    checks++; if (bus.o_data !== 134'd0) begin errors++; $display("FAIL reset_data: got %0h expected 0", bus.o_data); end
    checks++; if (bus.o_meta_valid !== 1'b0) begin errors++; $display("FAIL reset_meta_valid: got %0b expected 0", bus.o_meta_valid); end
    checks++; if (bus.o_meta !== {META_W{1'b0}}) begin errors++; $display("FAIL reset_meta: got %0h expected 0", bus.o_meta); end
    checks++; if (bus.o_pkt_rden !== 1'b0) begin errors++; $display("FAIL reset_pkt_rden: got %0b expected 0", bus.o_pkt_rden); end
    checks++; if (bus.o_meta_rden !== 1'b0) begin errors++; $display("FAIL reset_meta_rden: got %0b expected 0", bus.o_meta_rden); end
    checks++; if (bus.o_pkt_cnt !== 32'd0) begin errors++; $display("FAIL reset_pkt_cnt: got %0d expected 0", bus.o_pkt_cnt); end
    checks++; if (bus.o_err_cnt !== 32'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", bus.o_err_cnt); end
  endtask

  task automatic test_three_beat();
    int k;
    bit to;
    do_reset();
    ready_now = 1'b1;
    stream_q.push_back(mk_beat(2'b01)); stream_q.push_back(mk_beat(2'b00)); stream_q.push_back(mk_beat(2'b10));
    smeta_q.push_back({4{32'hA5A5_A5A5}});
    ref_model(); load();
    k = cyc;
    run_drain(50, to);
    checks++; if (to) begin errors++; $display("FAIL three_beat_timeout: beats %0d of %0d", got.size(), exp_q.size()); end
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL three_beat_count: got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i].d !== exp_q[i].d || got[i].mv !== exp_q[i].mv || (exp_q[i].mv && got[i].m !== exp_q[i].m) || got[i].cyc != k + 1 + i)
        begin errors++; $display("FAIL three_beat_beat%0d: got d=%0h mv=%0b m=%0h cyc=%0d expected d=%0h mv=%0b m=%0h cyc=%0d",
          i, got[i].d, got[i].mv, got[i].m, got[i].cyc, exp_q[i].d, exp_q[i].mv, exp_q[i].m, k + 1 + i); end
    end
    checks++; if (bus.o_pkt_cnt !== 32'(CNT_ON ? 1 : 0)) begin errors++; $display("FAIL three_beat_pkt_cnt: got %0d expected %0d", bus.o_pkt_cnt, CNT_ON ? 1 : 0); end
  endtask

  task automatic test_meta_wait();
    int k;
    bit to;
    do_reset();
    ready_now = 1'b1;
    stream_q.push_back(mk_beat(2'b01)); stream_q.push_back(mk_beat(2'b10));
    smeta_q.push_back(rnd_meta());
    ref_model();
    foreach (stream_q[i]) pkt_q.push_back(stream_q[i]);
    drive_fifo();
    repeat (5) cycle();
    checks++; if (pkt_pops != 0 || got.size() != 0) begin errors++; $display("FAIL meta_wait_nopop: pops=%0d beats=%0d expected 0 0", pkt_pops, got.size()); end
    meta_q.push_back(smeta_q[0]);
    drive_fifo();
    k = cyc;
    run_drain(50, to);
    checks++; if (to || got.size() != exp_q.size()) begin errors++; $display("FAIL meta_wait_count: got %0d beats expected %0d timeout=%0b", got.size(), exp_q.size(), to); end
    checks++; if (got.size() == 0 || got[0].cyc != k + 1) begin errors++; $display("FAIL meta_wait_first: got cyc %0d expected %0d", (got.size() != 0) ? got[0].cyc : -1, k + 1); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i].d !== exp_q[i].d || got[i].mv !== exp_q[i].mv || (exp_q[i].mv && got[i].m !== exp_q[i].m))
        begin errors++; $display("FAIL meta_wait_beat%0d: got d=%0h mv=%0b expected d=%0h mv=%0b", i, got[i].d, got[i].mv, exp_q[i].d, exp_q[i].mv); end
    end
  endtask

  task automatic test_single_then_two();
    int k;
    bit to;
    int exp_cyc[3] = '{1, 3, 4};
    do_reset();
    ready_now = 1'b1;
    stream_q.push_back(mk_beat(2'b11)); stream_q.push_back(mk_beat(2'b01)); stream_q.push_back(mk_beat(2'b10));
    ref_model(); load();
    k = cyc;
    run_drain(50, to);
    checks++; if (to || got.size() != 3) begin errors++; $display("FAIL single_two_count: got %0d beats expected 3 timeout=%0b", got.size(), to); end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      checks++;
      if (got[i].d !== exp_q[i].d || got[i].mv !== exp_q[i].mv || (exp_q[i].mv && got[i].m !== exp_q[i].m) || got[i].cyc != k + exp_cyc[i])
        begin errors++; $display("FAIL single_two_beat%0d: got d=%0h mv=%0b cyc=%0d expected d=%0h mv=%0b cyc=%0d",
          i, got[i].d, got[i].mv, got[i].cyc, exp_q[i].d, exp_q[i].mv, k + exp_cyc[i]); end
    end
    checks++; if (meta_pops != 2) begin errors++; $display("FAIL single_two_meta_pops: got %0d expected 2", meta_pops); end
    checks++; if (bus.o_pkt_cnt !== 32'(CNT_ON ? 2 : 0)) begin errors++; $display("FAIL single_two_pkt_cnt: got %0d expected %0d", bus.o_pkt_cnt, CNT_ON ? 2 : 0); end
  endtask

  task automatic test_orphan_drop();
    bit to;
    do_reset();
    ready_now = 1'b1;
    stream_q.push_back(mk_beat(2'b00)); stream_q.push_back(mk_beat(2'b00)); stream_q.push_back(mk_beat(2'b10));
    stream_q.push_back(mk_beat(2'b01)); stream_q.push_back(mk_beat(2'b10));
    ref_model(); load();
    run_drain(50, to);
    checks++; if (to || got.size() != exp_q.size()) begin errors++; $display("FAIL orphan_count: got %0d beats expected %0d timeout=%0b", got.size(), exp_q.size(), to); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i].d !== exp_q[i].d || got[i].mv !== exp_q[i].mv || (exp_q[i].mv && got[i].m !== exp_q[i].m))
        begin errors++; $display("FAIL orphan_beat%0d: got d=%0h mv=%0b m=%0h expected d=%0h mv=%0b m=%0h", i, got[i].d, got[i].mv, got[i].m, exp_q[i].d, exp_q[i].mv, exp_q[i].m); end
    end
    checks++; if (bus.o_err_cnt !== 32'(CNT_ON ? exp_err : 0)) begin errors++; $display("FAIL orphan_err_cnt: got %0d expected %0d", bus.o_err_cnt, CNT_ON ? exp_err : 0); end
    checks++; if (bus.o_pkt_cnt !== 32'(CNT_ON ? exp_pkt : 0)) begin errors++; $display("FAIL orphan_pkt_cnt: got %0d expected %0d", bus.o_pkt_cnt, CNT_ON ? exp_pkt : 0); end
    checks++; if (meta_pops != 1 || meta_q.size() != 0) begin errors++; $display("FAIL orphan_meta: pops=%0d left=%0d expected 1 0", meta_pops, meta_q.size()); end
  endtask

  task automatic test_backpressure();
    int k;
    int exp_cyc[4] = '{1, 4, 5, 6};
    do_reset();
    stream_q.push_back(mk_beat(2'b01)); stream_q.push_back(mk_beat(2'b00));
    stream_q.push_back(mk_beat(2'b00)); stream_q.push_back(mk_beat(2'b10));
    ref_model(); load();
    k = cyc;
    for (int j = 0; j < 12; j++) begin
      ready_now = !(j == 1 || j == 2);
      drive_fifo();
      cycle();
      checks++;
      if (pr_last && !ready_last) begin errors++; $display("FAIL bp_pop_not_ready: pop in cycle %0d with ready=0", j); end
    end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL bp_count: got %0d beats expected 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++;
      if (got[i].d !== exp_q[i].d || got[i].mv !== exp_q[i].mv || got[i].cyc != k + exp_cyc[i])
        begin errors++; $display("FAIL bp_beat%0d: got d=%0h mv=%0b cyc=%0d expected d=%0h mv=%0b cyc=%0d",
          i, got[i].d, got[i].mv, got[i].cyc, exp_q[i].d, exp_q[i].mv, k + exp_cyc[i]); end
    end
  endtask

  task automatic test_reset_mid_body();
    bit to;
    do_reset();
    ready_now = 1'b1;
    stream_q.push_back(mk_beat(2'b01)); stream_q.push_back(mk_beat(2'b00));
    stream_q.push_back(mk_beat(2'b00)); stream_q.push_back(mk_beat(2'b10));
    ref_model(); load();
    cycle(); cycle();
    checks++; if (got.size() != 2) begin errors++; $display("FAIL rst_mid_pre: got %0d beats expected 2", got.size()); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_data_valid !== 1'b0 || bus.o_data !== 134'd0 || bus.o_meta_valid !== 1'b0 || bus.o_meta !== {META_W{1'b0}} ||
        bus.o_pkt_rden !== 1'b0 || bus.o_meta_rden !== 1'b0 || bus.o_pkt_cnt !== 32'd0 || bus.o_err_cnt !== 32'd0)
      begin errors++; $display("FAIL rst_mid_outputs: dv=%0b d=%0h mv=%0b rden=%0b mrden=%0b expected all 0",
        bus.o_data_valid, bus.o_data, bus.o_meta_valid, bus.o_pkt_rden, bus.o_meta_rden); end
    @(negedge clk);
    checks++; if (bus.o_pkt_rden !== 1'b0) begin errors++; $display("FAIL rst_mid_pop: got rden %0b expected 0 (FIFO non-empty)", bus.o_pkt_rden); end
    do_reset();
    ready_now = 1'b1;
    stream_q.push_back(mk_beat(2'b01)); stream_q.push_back(mk_beat(2'b10));
    ref_model(); load();
    run_drain(50, to);
    checks++; if (to || got.size() != exp_q.size()) begin errors++; $display("FAIL rst_mid_after_count: got %0d expected %0d timeout=%0b", got.size(), exp_q.size(), to); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i].d !== exp_q[i].d || got[i].mv !== exp_q[i].mv || (exp_q[i].mv && got[i].m !== exp_q[i].m))
        begin errors++; $display("FAIL rst_mid_after_beat%0d: got d=%0h mv=%0b expected d=%0h mv=%0b", i, got[i].d, got[i].mv, exp_q[i].d, exp_q[i].mv); end
    end
    checks++; if (bus.o_pkt_cnt !== 32'(CNT_ON ? 1 : 0)) begin errors++; $display("FAIL rst_mid_pkt_cnt: got %0d expected %0d", bus.o_pkt_cnt, CNT_ON ? 1 : 0); end
  endtask

  task automatic test_random();
    int bi = 0;
    int mi = 0;
    int n = 0;
    int kind, len;
    do_reset();
    for (int p = 0; p < 40; p++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        len = $urandom_range(0, 2);
        for (int b = 0; b < len; b++) stream_q.push_back(mk_beat(2'b00));
        stream_q.push_back(mk_beat(2'b10));
      end else if (kind == 1 && p != 39) begin
        len = $urandom_range(0, 2);
        stream_q.push_back(mk_beat(2'b01));
        for (int b = 0; b < len; b++) stream_q.push_back(mk_beat(2'b00));
      end else begin
        len = $urandom_range(1, 5);
        if (len == 1) begin
          stream_q.push_back(mk_beat(2'b11));
        end else begin
          stream_q.push_back(mk_beat(2'b01));
          for (int b = 0; b < len - 2; b++) stream_q.push_back(mk_beat(2'b00));
          stream_q.push_back(mk_beat(2'b10));
        end
      end
    end
    ref_model();
    while (!(bi >= stream_q.size() && mi >= smeta_q.size() && pkt_q.size() == 0 && got.size() >= exp_q.size()) && n < 4000) begin
      if (bi < stream_q.size() && $urandom_range(0, 3) != 0) begin pkt_q.push_back(stream_q[bi]); bi++; end
      if (mi < smeta_q.size() && $urandom_range(0, 1) != 0) begin meta_q.push_back(smeta_q[mi]); mi++; end
      ready_now = ($urandom_range(0, 3) != 0);
      drive_fifo();
      cycle();
      n++;
    end
    ready_now = 1'b1;
    drive_fifo();
    repeat (3) cycle();
    checks++; if (n >= 4000) begin errors++; $display("FAIL rand_timeout: beats %0d of %0d, pkt left %0d", got.size(), exp_q.size(), pkt_q.size()); end
    checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d beats expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i].d !== exp_q[i].d || got[i].mv !== exp_q[i].mv || (exp_q[i].mv && got[i].m !== exp_q[i].m))
        begin errors++; $display("FAIL rand_beat%0d: got d=%0h mv=%0b m=%0h expected d=%0h mv=%0b m=%0h", i, got[i].d, got[i].mv, got[i].m, exp_q[i].d, exp_q[i].mv, exp_q[i].m); end
    end
    checks++; if (meta_pops != smeta_q.size() || meta_q.size() != 0) begin errors++; $display("FAIL rand_meta: pops=%0d left=%0d expected %0d 0", meta_pops, meta_q.size(), smeta_q.size()); end
    checks++; if (bus.o_pkt_cnt !== 32'(CNT_ON ? exp_pkt : 0)) begin errors++; $display("FAIL rand_pkt_cnt: got %0d expected %0d", bus.o_pkt_cnt, CNT_ON ? exp_pkt : 0); end
    checks++; if (bus.o_err_cnt !== 32'(CNT_ON ? exp_err : 0)) begin errors++; $display("FAIL rand_err_cnt: got %0d expected %0d", bus.o_err_cnt, CNT_ON ? exp_err : 0); end
  endtask

  initial begin
    ready_now = 1'b0;
    drive_fifo();
    test_reset();
    test_three_beat();
    test_meta_wait();
    test_single_then_two();
    test_orphan_drop();
    test_backpressure();
    test_reset_mid_body();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
